canny_frame_ctrl: RTL and testbench
===================================

Name: canny_frame_ctrl

Overview:
- Frame-level sequencer and configuration owner for the Canny gradient stage (Sobel, CORDIC magnitude/angle and double threshold).
- Arms on software start and locks onto the next frame's vsync. Holds the gradient pipeline enable through the frame plus a flush window.
- Applies double-threshold values only at frame boundaries. Checks line and frame geometry, and counts completed frames.
- Sits between the preceding median/filter stage output timing and the gradient block's enable and threshold inputs.

Parameters:
- IMG_WIDTH, 640, active pixels per line (de count per hs).
- IMG_HEIGHT, 480, active lines per frame (hs pulses per vs).
- THR_LOW_DEF, 50, reset value of the low threshold.
- THR_HIGH_DEF, 100, reset value of the high threshold.
- PIPE_LAT, 11, gradient pipeline latency in cycles, used as the flush length; must be ≥1.

Ports:
- clk  in  1  system clock.
- rst_s  in  1  synchronous reset, active-high.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  2  0 = low threshold, 1 = high threshold, 2 = control (bit0 = continuous mode); 3 = no effect.
- cfg_wdata  in  10  config write data.
- start  in  1  one-cycle run request.
- stop  in  1  one-cycle halt request.
- per_vs  in  1  input frame vsync, active-high.
- per_hs  in  1  input line valid.
- per_de  in  1  input pixel valid.
- thr_low  out  10  active low threshold.
- thr_high  out  10  active high threshold.
- pipe_en  out  1  gradient pipeline enable.
- busy  out  1  state ≠ IDLE.
- frame_done  out  1  one-cycle completion pulse.
- frame_cnt  out  16  completed frames; wraps 0xFFFF→0.
- err_line  out  1  sticky line-length error.
- err_frame  out  1  sticky line-count error.
- err_cfg  out  1  sticky invalid-threshold error.

Behaviour:
- Reset (sync, rst_s=1): state IDLE, thr_low=THR_LOW_DEF, thr_high=THR_HIGH_DEF, shadow regs = same, continuous=0, pipe_en=0, busy=0, frame_done=0, frame_cnt=0, all err_* = 0, counters = 0, stop_pending=0. Reset mid-frame aborts immediately.
- Edge detect: per_vs/per_hs registered once. vs_rise = per_vs & ~per_vs_d; vs_fall = ~per_vs & per_vs_d; hs_fall = ~per_hs & per_hs_d.
- Config: cfg_we writes the shadow register in any state, effective next cycle. Active thresholds change only on a frame load.
- FSM:
  - IDLE: start=1 and stop=0 → ARMED; clears all err_* the same edge. start with stop in the same cycle → stay IDLE.
  - ARMED: stop → IDLE. On vs_rise at cycle T → RUN at T+1 with a frame load:
    - If shadow_low < shadow_high, thr_low/thr_high ← shadow values at T+1.
    - Otherwise the active values are kept and err_cfg is set.
  - RUN: col_cnt (11 b) increments on per_de & per_hs. On hs_fall:
    - err_line is set if col_cnt ≠ IMG_WIDTH.
    - col_cnt ← 0, row_cnt (10 b) +1.
  - RUN, vs_fall at cycle F: err_frame is set if (row_cnt + hs_fall) ≠ IMG_HEIGHT, so a coincident hs_fall counts. Then → FLUSH, and row_cnt/col_cnt ← 0.
  - FLUSH: occupies cycles F+1..F+PIPE_LAT, timed by a down-counter. At exit:
    - frame_done=1 for the single cycle F+PIPE_LAT+1, and frame_cnt +1 the same cycle.
    - Next state is ARMED if continuous=1 and stop_pending=0, else IDLE.
    - stop_pending is cleared.
  - stop in RUN or FLUSH sets stop_pending; the frame completes normally. start in non-IDLE states is ignored.
- pipe_en = 1 exactly in RUN and FLUSH, decoded from the state register.
- de coincident with vs_rise is not counted; de with per_hs=0 is ignored.
- vs_rise in RUN is ignored (no resync); geometry errors report the consequences.
- Counters saturate at all-ones rather than wrap.

Test Plan:
- IMG_WIDTH=8, IMG_HEIGHT=4, PIPE_LAT=11 for all scenarios.
- Reset, then start, then a clean frame (vs rise T, four lines of 8 de, vs fall F) → pipe_en high T+1..F+11; frame_done pulse at F+12; frame_cnt=1; busy=0 at F+12; no errors.
- Write low=30, high=120 while in RUN → thr stays 50/100 for the current frame. Continuous=1; next vs rise at T2 → thr = 30/120 at T2+1.
- Shadow low=120, high=30, then start and vs rise → thr keeps its prior values; err_cfg=1; frame still runs; frame_done pulses.
- Line 2 carries 7 de → err_line=1 after that hs_fall, err_frame=0. Frame with 3 lines → err_frame=1. Both flags clear on the next start from IDLE.
- Continuous=1, stop pulsed mid-RUN → the frame completes; frame_done pulses; state IDLE; a following vs rise leaves pipe_en low.
- rst_s asserted mid-RUN → next cycle pipe_en=0, busy=0, frame_cnt=0, thr=50/100. start with stop in the same cycle → stays IDLE.

Source files
------------

// File: rtl/canny_frame_ctrl.sv
// canny_frame_ctrl
// Frame-level sequencer and configuration owner for the Canny gradient stage.
// Arms on a software start, locks onto the next frame's vsync, holds the
// gradient pipeline enable through the frame plus a flush window, loads the
// double-threshold values only at frame boundaries, checks line/frame
// geometry and counts completed frames.
//
// Ports:
//   clk, rst_s            clock, synchronous active-high reset
//   cfg_we/addr/wdata     shadow config writes (0 low, 1 high, 2 control)
//   start, stop           one-cycle run / halt requests
//   per_vs, per_hs, per_de  upstream frame / line / pixel timing
//   thr_low, thr_high     active thresholds for the gradient block
//   pipe_en               gradient pipeline enable (RUN and FLUSH)
//   busy                  sequencer not idle
//   frame_done            one-cycle pulse when a frame has fully flushed
//   frame_cnt             completed frame count (wraps)
//   err_line, err_frame, err_cfg  sticky geometry / threshold errors
module canny_frame_ctrl #(
  parameter int IMG_WIDTH    = 640,
  parameter int IMG_HEIGHT   = 480,
  parameter int THR_LOW_DEF  = 50,
  parameter int THR_HIGH_DEF = 100,
  parameter int PIPE_LAT     = 11
) (
  input  logic        clk,
  input  logic        rst_s,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [9:0]  cfg_wdata,
  input  logic        start,
  input  logic        stop,
  input  logic        per_vs,
  input  logic        per_hs,
  input  logic        per_de,
  output logic [9:0]  thr_low,
  output logic [9:0]  thr_high,
  output logic        pipe_en,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        err_line,
  output logic        err_frame,
  output logic        err_cfg
);

  // Flush down-counter is loaded with PIPE_LAT-1 so it spans exactly PIPE_LAT cycles.
  localparam int FW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(PIPE_LAT - 1);
  localparam logic [FW-1:0] FLUSH_ONE  = FW'(1);
  localparam logic [FW-1:0] FLUSH_ZERO = FW'(0);
  localparam logic [10:0]   WIDTH_EXP  = 11'(IMG_WIDTH);
  localparam logic [10:0]   HEIGHT_EXP = 11'(IMG_HEIGHT);
  localparam logic [9:0]    LOW_DEF    = 10'(THR_LOW_DEF);
  localparam logic [9:0]    HIGH_DEF   = 10'(THR_HIGH_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t         state_r;
  state_t         next_state_s;
  logic           per_vs_d_r;
  logic           per_hs_d_r;
  logic [9:0]     shadow_low_r;
  logic [9:0]     shadow_high_r;
  logic           continuous_r;
  logic [10:0]    col_cnt_r;
  logic [9:0]     row_cnt_r;
  logic [FW-1:0]  flush_cnt_r;
  logic           stop_pending_r;
  logic [9:0]     thr_low_r;
  logic [9:0]     thr_high_r;
  logic           frame_done_r;
  logic [15:0]    frame_cnt_r;
  logic           err_line_r;
  logic           err_frame_r;
  logic           err_cfg_r;

  logic           vs_rise_s;
  logic           vs_fall_s;
  logic           hs_fall_s;
  logic           frame_load_s;
  logic           arm_s;
  logic           flush_done_s;
  logic [10:0]    rows_seen_s;

  // A threshold pair is usable only when low is strictly below high.
  function automatic logic thr_valid(input logic [9:0] lo, input logic [9:0] hi);
    return (lo < hi);
  endfunction

  assign vs_rise_s    = per_vs & ~per_vs_d_r;
  assign vs_fall_s    = ~per_vs & per_vs_d_r;
  assign hs_fall_s    = ~per_hs & per_hs_d_r;
  // stop wins over a coincident vsync while armed, so no load happens then.
  assign frame_load_s = (state_r == ARMED) & vs_rise_s & ~stop;
  assign arm_s        = (state_r == IDLE) & start & ~stop;
  assign flush_done_s = (state_r == FLUSH) & (flush_cnt_r == FLUSH_ZERO);
  // A line ending in the same cycle as vsync still counts toward the frame.
  assign rows_seen_s  = {1'b0, row_cnt_r} + {10'd0, hs_fall_s};

  assign pipe_en    = (state_r == RUN) | (state_r == FLUSH);
  assign busy       = (state_r != IDLE);
  assign thr_low    = thr_low_r;
  assign thr_high   = thr_high_r;
  assign frame_done = frame_done_r;
  assign frame_cnt  = frame_cnt_r;
  assign err_line   = err_line_r;
  assign err_frame  = err_frame_r;
  assign err_cfg    = err_cfg_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst_s) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start && !stop) begin
          next_state_s = ARMED;
        end else begin
          next_state_s = IDLE;
        end
      end
      ARMED: begin
        if (stop) begin
          next_state_s = IDLE;
        end else if (vs_rise_s) begin
          next_state_s = RUN;
        end else begin
          next_state_s = ARMED;
        end
      end
      RUN: begin
        if (vs_fall_s) begin
          next_state_s = FLUSH;
        end else begin
          next_state_s = RUN;
        end
      end
      FLUSH: begin
        if (flush_cnt_r != FLUSH_ZERO) begin
          next_state_s = FLUSH;
        end else if (continuous_r && !(stop_pending_r || stop)) begin
          next_state_s = ARMED;
        end else begin
          next_state_s = IDLE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // One-cycle delayed copies of vsync/hsync for edge detection.
  always_ff @(posedge clk) begin
    if (rst_s) begin
      per_vs_d_r <= 1'b0;
      per_hs_d_r <= 1'b0;
    end else begin
      per_vs_d_r <= per_vs;
      per_hs_d_r <= per_hs;
    end
  end

  // Shadow configuration, writable in any state.
  always_ff @(posedge clk) begin
    if (rst_s) begin
      shadow_low_r  <= LOW_DEF;
      shadow_high_r <= HIGH_DEF;
      continuous_r  <= 1'b0;
    end else if (cfg_we) begin
      case (cfg_addr)
        2'd0:    shadow_low_r  <= cfg_wdata;
        2'd1:    shadow_high_r <= cfg_wdata;
        2'd2:    continuous_r  <= cfg_wdata[0];
        default: continuous_r  <= continuous_r;
      endcase
    end
  end

  // Active thresholds, loaded only on the frame that enters RUN.
  always_ff @(posedge clk) begin
    if (rst_s) begin
      thr_low_r  <= LOW_DEF;
      thr_high_r <= HIGH_DEF;
    end else if (frame_load_s && thr_valid(shadow_low_r, shadow_high_r)) begin
      thr_low_r  <= shadow_low_r;
      thr_high_r <= shadow_high_r;
    end
  end

  // Sticky error flags; a fresh start from IDLE clears them all.
  always_ff @(posedge clk) begin
    if (rst_s || arm_s) begin
      err_line_r  <= 1'b0;
      err_frame_r <= 1'b0;
      err_cfg_r   <= 1'b0;
    end else begin
      if (frame_load_s && !thr_valid(shadow_low_r, shadow_high_r)) begin
        err_cfg_r <= 1'b1;
      end
      if ((state_r == RUN) && hs_fall_s && (col_cnt_r != WIDTH_EXP)) begin
        err_line_r <= 1'b1;
      end
      if ((state_r == RUN) && vs_fall_s && (rows_seen_s != HEIGHT_EXP)) begin
        err_frame_r <= 1'b1;
      end
    end
  end

  // Pixel and line counters, saturating, active only in RUN.
  always_ff @(posedge clk) begin
    if (rst_s || (state_r != RUN) || vs_fall_s) begin
      col_cnt_r <= 11'd0;
      row_cnt_r <= 10'd0;
    end else if (hs_fall_s) begin
      col_cnt_r <= 11'd0;
      if (row_cnt_r != 10'h3FF) begin
        row_cnt_r <= row_cnt_r + 10'd1;
      end
    end else if (per_de && per_hs && !vs_rise_s && (col_cnt_r != 11'h7FF)) begin
      col_cnt_r <= col_cnt_r + 11'd1;
    end
  end

  // Flush window timer.
  always_ff @(posedge clk) begin
    if (rst_s) begin
      flush_cnt_r <= FLUSH_ZERO;
    end else if ((state_r == RUN) && vs_fall_s) begin
      flush_cnt_r <= FLUSH_LOAD;
    end else if ((state_r == FLUSH) && (flush_cnt_r != FLUSH_ZERO)) begin
      flush_cnt_r <= flush_cnt_r - FLUSH_ONE;
    end
  end

  // Deferred stop: remembered during a frame, consumed at flush exit.
  always_ff @(posedge clk) begin
    if (rst_s || flush_done_s) begin
      stop_pending_r <= 1'b0;
    end else if (stop && ((state_r == RUN) || (state_r == FLUSH))) begin
      stop_pending_r <= 1'b1;
    end
  end

  // Completion pulse and frame counter.
  always_ff @(posedge clk) begin
    if (rst_s) begin
      frame_done_r <= 1'b0;
      frame_cnt_r  <= 16'd0;
    end else begin
      frame_done_r <= flush_done_s;
      if (flush_done_s) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_canny_frame_ctrl.sv
// Directed testbench for canny_frame_ctrl with a small geometry
// (8 pixels x 4 lines, 11-cycle flush).
module tb_canny_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst_s = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [9:0]  cfg_wdata = 10'd0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        per_vs = 1'b0;
  logic        per_hs = 1'b0;
  logic        per_de = 1'b0;
  logic [9:0]  thr_low;
  logic [9:0]  thr_high;
  logic        pipe_en;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic        err_line;
  logic        err_frame;
  logic        err_cfg;

  int n_vec = 0;
  int n_err = 0;

  canny_frame_ctrl #(
    .IMG_WIDTH(8), .IMG_HEIGHT(4), .THR_LOW_DEF(50), .THR_HIGH_DEF(100), .PIPE_LAT(11)
  ) dut (
    .clk(clk), .rst_s(rst_s), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .start(start), .stop(stop), .per_vs(per_vs), .per_hs(per_hs), .per_de(per_de),
    .thr_low(thr_low), .thr_high(thr_high), .pipe_en(pipe_en), .busy(busy),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .err_line(err_line),
    .err_frame(err_frame), .err_cfg(err_cfg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [1:0]  addr;
    logic [9:0]  wdata;
    logic        st;
    logic        sp;
    logic        e_busy;
    logic        e_pe;
    logic [9:0]  e_lo;
    logic [9:0]  e_hi;
    logic [15:0] e_cnt;
    logic [2:0]  e_err;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [9:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  // vsync rises in cycle T; RUN and the frame load are visible in T+1.
  task automatic frame_begin(input logic [9:0] el, input logic [9:0] eh);
    per_vs = 1'b1;
    chk("pe_before_vs", pipe_en, 1'b0);
    tick();
    chk("pe_run", pipe_en, 1'b1);
    chk("thr_low_load", thr_low, el);
    chk("thr_high_load", thr_high, eh);
  endtask

  // n_de pixels, then hsync low; the low cycle is skipped when the caller
  // wants it to coincide with the vsync fall.
  task automatic send_line(input int n_de, input bit fall_tick);
    per_hs = 1'b1; per_de = 1'b1;
    for (int i = 0; i < n_de; i++) tick();
    per_hs = 1'b0; per_de = 1'b0;
    if (fall_tick) tick();
  endtask

  // vsync falls in cycle F; pipe_en holds through F+11, frame_done at F+12.
  task automatic frame_end(input logic e_busy, input logic [15:0] e_cnt, input logic e_ferr);
    per_vs = 1'b0;
    tick();
    for (int k = 0; k < 11; k++) begin
      chk("pe_flush", pipe_en, 1'b1);
      chk("done_early", frame_done, 1'b0);
      tick();
    end
    chk("done_pulse", frame_done, 1'b1);
    chk("pe_after_flush", pipe_en, 1'b0);
    chk("frame_cnt", frame_cnt, e_cnt);
    chk("busy_after", busy, e_busy);
    chk("err_frame", err_frame, e_ferr);
    tick();
    chk("done_single", frame_done, 1'b0);
  endtask

  initial begin
    //            rst   we    addr  wdata      st    sp    busy  pe    lo      hi       cnt     err{line,frame,cfg}
    tbl[0] = '{1'b1, 1'b0, 2'd0, 10'd0,    1'b0, 1'b0, 1'b0, 1'b0, 10'd50, 10'd100, 16'd0, 3'b000};
    tbl[1] = '{1'b0, 1'b0, 2'd0, 10'd0,    1'b1, 1'b1, 1'b0, 1'b0, 10'd50, 10'd100, 16'd0, 3'b000};
    tbl[2] = '{1'b0, 1'b1, 2'd3, 10'h3FF,  1'b0, 1'b0, 1'b0, 1'b0, 10'd50, 10'd100, 16'd0, 3'b000};
    tbl[3] = '{1'b0, 1'b1, 2'd0, 10'd30,   1'b0, 1'b0, 1'b0, 1'b0, 10'd50, 10'd100, 16'd0, 3'b000};
    tbl[4] = '{1'b0, 1'b0, 2'd0, 10'd0,    1'b1, 1'b0, 1'b1, 1'b0, 10'd50, 10'd100, 16'd0, 3'b000};
    tbl[5] = '{1'b0, 1'b0, 2'd0, 10'd0,    1'b1, 1'b0, 1'b1, 1'b0, 10'd50, 10'd100, 16'd0, 3'b000};
    tbl[6] = '{1'b0, 1'b0, 2'd0, 10'd0,    1'b0, 1'b1, 1'b0, 1'b0, 10'd50, 10'd100, 16'd0, 3'b000};
    tbl[7] = '{1'b1, 1'b0, 2'd0, 10'd0,    1'b0, 1'b0, 1'b0, 1'b0, 10'd50, 10'd100, 16'd0, 3'b000};

    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      rst_s = tbl[i].rst; cfg_we = tbl[i].we; cfg_addr = tbl[i].addr; cfg_wdata = tbl[i].wdata;
      start = tbl[i].st; stop = tbl[i].sp;
      tick();
      chk("tbl_busy", busy, tbl[i].e_busy);
      chk("tbl_pipe_en", pipe_en, tbl[i].e_pe);
      chk("tbl_thr_low", thr_low, tbl[i].e_lo);
      chk("tbl_thr_high", thr_high, tbl[i].e_hi);
      chk("tbl_frame_cnt", frame_cnt, tbl[i].e_cnt);
      chk("tbl_frame_done", frame_done, 1'b0);
      chk("tbl_err", {err_line, err_frame, err_cfg}, tbl[i].e_err);
    end
    rst_s = 1'b0; cfg_we = 1'b0; start = 1'b0; stop = 1'b0;
    tick();

    // Clean single frame.
    pulse_start();
    chk("busy_armed", busy, 1'b1);
    frame_begin(10'd50, 10'd100);
    for (int l = 0; l < 4; l++) send_line(8, 1'b1);
    frame_end(1'b0, 16'd1, 1'b0);
    chk("clean_errs", {err_line, err_cfg}, 2'b00);

    // Continuous mode; thresholds written mid-frame apply on the next frame.
    cfg_write(2'd2, 10'd1);
    pulse_start();
    frame_begin(10'd50, 10'd100);
    cfg_write(2'd0, 10'd30);
    cfg_write(2'd1, 10'd120);
    tick();
    chk("thr_low_hold", thr_low, 10'd50);
    chk("thr_high_hold", thr_high, 10'd100);
    for (int l = 0; l < 4; l++) send_line(8, 1'b1);
    frame_end(1'b1, 16'd2, 1'b0);
    tick();
    frame_begin(10'd30, 10'd120);
    send_line(8, 1'b1);
    pulse_stop();
    for (int l = 0; l < 3; l++) send_line(8, 1'b1);
    frame_end(1'b0, 16'd3, 1'b0);
    per_vs = 1'b1;
    tick();
    chk("pe_after_stop_a", pipe_en, 1'b0);
    tick();
    chk("pe_after_stop_b", pipe_en, 1'b0);
    per_vs = 1'b0;
    tick();

    // Inverted thresholds: keep active values, flag err_cfg, frame still runs.
    cfg_write(2'd2, 10'd0);
    cfg_write(2'd0, 10'd120);
    cfg_write(2'd1, 10'd30);
    pulse_start();
    frame_begin(10'd30, 10'd120);
    chk("err_cfg_set", err_cfg, 1'b1);
    for (int l = 0; l < 4; l++) send_line(8, 1'b1);
    frame_end(1'b0, 16'd4, 1'b0);
    chk("err_cfg_sticky", err_cfg, 1'b1);

    // Geometry errors over two back-to-back frames in continuous mode.
    cfg_write(2'd0, 10'd40);
    cfg_write(2'd1, 10'd90);
    cfg_write(2'd2, 10'd1);
    pulse_start();
    chk("err_cfg_cleared", err_cfg, 1'b0);
    frame_begin(10'd40, 10'd90);
    send_line(8, 1'b1);
    chk("err_line_pre", err_line, 1'b0);
    send_line(7, 1'b1);
    chk("err_line_short", err_line, 1'b1);
    send_line(8, 1'b1);
    send_line(8, 1'b1);
    frame_end(1'b1, 16'd5, 1'b0);
    tick();
    frame_begin(10'd40, 10'd90);
    pulse_stop();
    for (int l = 0; l < 3; l++) send_line(8, 1'b1);
    frame_end(1'b0, 16'd6, 1'b1);
    chk("err_line_kept", err_line, 1'b1);
    pulse_start();
    chk("errs_cleared", {err_line, err_frame, err_cfg}, 3'b000);

    // Last hsync fall coincides with vsync fall: still four lines.
    frame_begin(10'd40, 10'd90);
    pulse_stop();
    for (int l = 0; l < 3; l++) send_line(8, 1'b1);
    send_line(8, 1'b0);
    frame_end(1'b0, 16'd7, 1'b0);
    chk("coinc_err_line", err_line, 1'b0);

    // Reset mid-frame aborts; start with stop stays idle.
    pulse_start();
    frame_begin(10'd40, 10'd90);
    send_line(8, 1'b1);
    per_hs = 1'b1; per_de = 1'b1;
    tick();
    tick();
    rst_s = 1'b1;
    tick();
    rst_s = 1'b0; per_hs = 1'b0; per_de = 1'b0; per_vs = 1'b0;
    chk("rst_pe", pipe_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cnt", frame_cnt, 16'd0);
    chk("rst_thr_low", thr_low, 10'd50);
    chk("rst_thr_high", thr_high, 10'd100);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("start_stop_idle", busy, 1'b0);
    tick();
    chk("start_stop_idle2", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
